dedicate_micro_processor: RTL and testbench
===========================================

DEDICATE_MICRO_PROCESSOR -- requirements
Module: dedicate_micro_processor

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 N  input  8  operand word, sampled once per run (unsigned, bit 0 = LSB).
REQ-005 led  output  1  registered result flag: 1 = N contains exactly four 1-bits (equal count of 0s and 1s).

Function
REQ-006 The block SHALL be partitioned into a controller FSM plus datapath.
- Datapath: 8-bit shift register SR, 4-bit ones counter ONES, 4-bit bit counter CNT, led register.
REQ-007 FSM states SHALL be INIT, SHIFT, CHECK, DONE, held in a registered state variable.
REQ-008 INIT: on the first rising edge with rst=0, the FSM SHALL set SR<=N, ONES<=0 and CNT<=0, and go to SHIFT.
REQ-009 SHIFT: each edge SHALL do the following, staying in SHIFT while CNT<7:
- ONES<=ONES+SR[0]
- SR<=SR>>1, zero-filled
- CNT<=CNT+1
REQ-010 SHIFT with CNT==7: the edge SHALL perform the final shift/accumulate and go to CHECK, giving exactly 8 shift cycles.
REQ-011 CHECK: the edge SHALL set led<=(ONES==4) and go to DONE.
REQ-012 DONE: the FSM SHALL hold all registers and led unchanged indefinitely until rst is asserted.
REQ-013 Latency: led SHALL be valid after the 10th rising edge following rst deassertion (1 INIT + 8 SHIFT + 1 CHECK).
REQ-014 led SHALL be 0 in INIT, SHIFT and CHECK; it SHALL be allowed to become 1 only on entry to DONE.
REQ-015 N SHALL be sampled only in INIT; changes to N during SHIFT, CHECK or DONE SHALL NOT affect the result.
REQ-016 ONES SHALL count 0..8 without overflow (4 bits).
REQ-017 Boundary values:
- N=0x00 and N=0xFF SHALL give led=0.
- Any N with popcount 4 SHALL give led=1.
- All other popcounts SHALL give led=0.
REQ-018 No handshake exists; a new computation SHALL start only via a reset pulse.

Reset
REQ-019 While rst=1 at a rising edge, the block SHALL set:
- state<=INIT
- SR<=0, ONES<=0, CNT<=0
- led<=0
REQ-020 rst SHALL take priority over every state transition, including mid-SHIFT and DONE.
REQ-021 Reset mid-operation SHALL abort the run with no residual state; the next run SHALL re-sample N.
REQ-022 Multi-cycle reset SHALL be equivalent to single-cycle reset.
REQ-023 led SHALL show no undefined value after the first reset edge.

Verification
REQ-024 N=0x02, reset 5 cycles, release, run 20 cycles -> led=0 throughout (popcount 1).
REQ-025 N=0x55, then 0x0F, 0xAA, 0x69, each preceded by a reset -> led=0 until edge 10, then led=1 and held to 20 cycles.
REQ-026 N=0x7F, 0x00, 0xFF, each run separately -> led stays 0.
REQ-027 N=0x55 run completes (led=1), then N=0x02 and reset -> led=0 during reset and stays 0.
REQ-028 N=0x0F, then N changed to 0x01 at edge 3 -> led=1 at edge 10 (sampling only in INIT).
REQ-029 N=0xAA, rst pulsed during SHIFT at edge 5, N=0x7F before release -> led=0; the new run yields led=0, not 1.

Source files
------------

// File: rtl/dedicate_micro_processor.sv
// Popcount-of-four detector: a controller FSM that sequences a shift/count datapath.
// Raises led after ten edges when the sampled operand has exactly four set bits.
module dedicate_micro_processor (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] N,
  output logic       led
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        led_q, led_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sr_q    <= 8'd0;
      ones_q  <= 4'd0;
      cnt_q   <= 4'd0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  // Default is to hold every register; DONE relies on this to freeze the result.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    case (state_q)
      INIT: begin
        sr_d    = N;
        ones_d  = 4'd0;
        cnt_d   = 4'd0;
        led_d   = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        ones_d = ones_q + {3'd0, sr_q[0]};
        sr_d   = {1'b0, sr_q[7:1]};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        led_d   = (ones_q == 4'd4);
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_dedicate_micro_processor.sv
// Directed bench for the popcount-of-four detector: led must stay 0 through
// edge 9 after reset release and carry the hand-computed result from edge 10 on.
module tb_dedicate_micro_processor;

  logic       clk;
  logic       rst;
  logic [7:0] N;
  logic       led;

  int tests_run;
  int tests_failed;

  dedicate_micro_processor dut (
    .clk (clk),
    .rst (rst),
    .N   (N),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: led=%b expected=%b", tag, actual, expected);
    end
  endtask

  // Hold reset for the given number of edges with N applied; led must read 0 after each.
  task automatic do_reset(input logic [7:0] n, input int cycles, input string tag);
    N   = n;
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_rst"}, led, 1'b0);
    end
    rst = 1'b0;
  endtask

  // Release reset and watch edges 1..edges; optionally change N after chg_edge.
  task automatic run_edges(input int edges, input logic exp, input int chg_edge,
                           input logic [7:0] chg_n, input string tag);
    for (int e = 1; e <= edges; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_e%0d", tag, e), led, (e >= 10) ? exp : 1'b0);
      if (e == chg_edge) N = chg_n;
    end
    $display("[TB] run %s N0=%h done, led=%b", tag, N, led);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    N            = 8'h00;

    // Popcount 1 with a long reset.
    do_reset(8'h02, 5, "n02");
    run_edges(20, 1'b0, 0, 8'h00, "n02");

    // Popcount 4 patterns.
    do_reset(8'h55, 1, "n55");
    run_edges(20, 1'b1, 0, 8'h00, "n55");
    do_reset(8'h0F, 1, "n0F");
    run_edges(20, 1'b1, 0, 8'h00, "n0F");
    do_reset(8'hAA, 2, "nAA");
    run_edges(20, 1'b1, 0, 8'h00, "nAA");
    do_reset(8'h69, 1, "n69");
    run_edges(20, 1'b1, 0, 8'h00, "n69");

    // Non-four popcounts: 7, 0, 8, 3, 5.
    do_reset(8'h7F, 1, "n7F");
    run_edges(20, 1'b0, 0, 8'h00, "n7F");
    do_reset(8'h00, 1, "n00");
    run_edges(20, 1'b0, 0, 8'h00, "n00");
    do_reset(8'hFF, 1, "nFF");
    run_edges(20, 1'b0, 0, 8'h00, "nFF");
    do_reset(8'h07, 1, "n07");
    run_edges(20, 1'b0, 0, 8'h00, "n07");
    do_reset(8'h1F, 1, "n1F");
    run_edges(20, 1'b0, 0, 8'h00, "n1F");

    // Completed run with led=1, then reset with a popcount-1 operand.
    do_reset(8'h55, 1, "seqA");
    run_edges(12, 1'b1, 0, 8'h00, "seqA");
    do_reset(8'h02, 1, "seqB");
    run_edges(20, 1'b0, 0, 8'h00, "seqB");

    // N changes mid-run; the INIT sample (0x0F) must decide the result.
    do_reset(8'h0F, 1, "chg");
    run_edges(20, 1'b1, 3, 8'h01, "chg");

    // Abort during SHIFT and restart with a popcount-7 operand.
    do_reset(8'hAA, 1, "abortA");
    run_edges(4, 1'b1, 0, 8'h00, "abortA");
    do_reset(8'h7F, 1, "abortB");
    run_edges(20, 1'b0, 0, 8'h00, "abortB");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
